alu64bit_serial: RTL and testbench
==================================

// Module: alu64bit_serial
// PURPOSE
//  Multi-cycle, slice-serial counterpart of the 64-bit ripple ALU. It takes one operand
//  set per valid/ready request and processes SLICE bits per clock from LSB to MSB.
//  Carry is kept in a flop between slices. The result is returned on a valid/ready
//  response port.
//  Used where a registered, handshaked ALU result is required and per-cycle carry
//  depth must stay at SLICE bits.
// PARAMETERS
//  WIDTH  64  operand/result width; must be a multiple of SLICE
//  SLICE   8  bits processed per CALC cycle; NSLICE = WIDTH/SLICE (default 8)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      request valid
//  in_ready   out  1      block can accept a request
//  a          in   WIDTH  operand A, sampled on accept
//  b          in   WIDTH  operand B, sampled on accept
//  cin        in   1      carry in, sampled on accept
//  op         in   2      operation, sampled on accept
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  s          out  WIDTH  result
//  cout       out  1      carry out of MSB
//  busy       out  1      FSM not in IDLE
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0,
//    s=0, cout=0, busy=0. Internal operand, working and counter regs are cleared.
//  - Ops, applied bitwise per slice with the carry chained across slices:
//    00 NOR, 01 XOR, 10 ADD (a+b+cin), 11 SUB (a+~b+cin; caller sets cin=1 for a-b).
//    For NOR/XOR, cout=0.
//  - FSM states and transitions:
//    - IDLE: in_ready=1. On in_valid&&in_ready, capture a, b, cin and op; cnt<=0;
//      go to CALC.
//    - CALC: in_ready=0. Each cycle compute slice cnt from {a,b}[cnt*SLICE +: SLICE]
//      and carry_q. Write the slice into the working reg; update carry_q; cnt++.
//      After slice NSLICE-1, copy the working reg to s, set cout=carry_q_next,
//      go to DONE.
//    - DONE: out_valid=1. s and cout hold stable while out_valid&&!out_ready.
//      On out_valid&&out_ready go to IDLE.
//  - Latency: with accept at edge E, out_valid is high after edge E+NSLICE.
//    Default: 8 cycles. Throughput is one op per NSLICE+2 cycles with out_ready tied high.
//  - in_ready is high only in IDLE. in_valid outside IDLE is ignored, with no queueing.
//    Input changes during CALC/DONE have no effect.
//  - s/cout change only on the CALC->DONE transition and hold the last result after
//    the response handshake. No partial results are ever visible on s.
//  - cnt wraps: it reaches NSLICE-1 exactly once per op and is reset on every accept.
//  - Reset mid-CALC or mid-DONE: the op is aborted. All outputs take their reset values
//    immediately, and no response is produced.
//  - For WIDTH%SLICE!=0, elaboration fails via $error in a generate check.
// STRUCTURE
//  - Package alu_pkg:
//    - typedef enum logic [1:0] alu_op_e {OP_NOR=2'b00, OP_XOR, OP_ADD, OP_SUB}
//    - typedef enum logic [1:0] alu_ser_state_e {S_IDLE, S_CALC, S_DONE}
//  - Sub-module alu_slice #(SLICE): a combinational SLICE-bit ripple chain of alu1bit
//    instances with ports a, b, cin, op, s, cout. Instantiated once and reused each
//    CALC cycle.
//  - Top module holds the FSM, the cnt counter ($clog2(NSLICE) bits), the carry_q flop,
//    the operand, working and result regs, and the handshake logic.
// TESTING
//  - ADD a=64'hFFFF_FFFF_FFFF_FFFF, b=0, cin=1 -> s=0, cout=1, out_valid 8 cycles
//    after accept.
//  - SUB a=5, b=7, cin=1 -> s=64'hFFFF_FFFF_FFFF_FFFE, cout=0.
//    SUB a=7, b=5, cin=1 -> s=2, cout=1.
//  - NOR a=64'hF0F0_F0F0_F0F0_F0F0, b=64'hFF00_FF00_FF00_FF00 -> s=64'h000F_000F_000F_000F,
//    cout=0. XOR on the same operands -> s=64'h0FF0_0FF0_0FF0_0FF0.
//  - Backpressure: hold out_ready=0 for 5 cycles in DONE -> s/cout/out_valid stable,
//    in_ready=0. A second in_valid is not accepted until after the response handshake.
//  - Reset mid-op: assert rst_n=0 at CALC slice 3 -> out_valid=0, s=0, in_ready=1
//    immediately. After release, a new ADD 1+1 -> s=2.
//  - Back-to-back: in_valid and out_ready held high with 20 random ops -> results match
//    the reference model in order, each op spaced NSLICE+2 cycles.

Source files
------------

// File: rtl/alu64bit_serial_pkg.sv
// Shared types for the slice-serial ALU: operation codes and FSM states.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_NOR = 2'b00,
    OP_XOR = 2'b01,
    OP_ADD = 2'b10,
    OP_SUB = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } alu_ser_state_e;

endpackage

// File: rtl/alu64bit_serial_if.sv
// Request/response handshake bundle for the slice-serial ALU.
interface alu64bit_serial_if
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  alu_op_e          op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;

  modport master (
    output in_valid, a, b, cin, op, out_ready,
    input  in_ready, out_valid, s, cout
  );

  modport slave (
    input  in_valid, a, b, cin, op, out_ready,
    output in_ready, out_valid, s, cout
  );

endinterface

// File: rtl/alu64bit_serial_slice.sv
// One-bit ALU cell and the SLICE-bit ripple chain built from it; purely combinational.
module alu1bit
  import alu_pkg::*;
(
  input  logic    a,
  input  logic    b,
  input  logic    cin,
  input  alu_op_e op,
  output logic    s,
  output logic    cout
);

  logic b_eff;

  always_comb begin
    s     = 1'b0;
    cout  = 1'b0;
    b_eff = (op == OP_SUB) ? ~b : b;
    case (op)
      OP_NOR: s = ~(a | b);
      OP_XOR: s = a ^ b;
      OP_ADD, OP_SUB: begin
        s    = a ^ b_eff ^ cin;
        cout = (a & b_eff) | (a & cin) | (b_eff & cin);
      end
      default: s = 1'b0;
    endcase
  end

endmodule

module alu_slice
  import alu_pkg::*;
#(
  parameter int unsigned SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  input  alu_op_e          op,
  output logic [SLICE-1:0] s,
  output logic             cout
);

  logic [SLICE:0] c;

  assign c[0] = cin;
  assign cout = c[SLICE];

  for (genvar i = 0; i < SLICE; i++) begin : g_bit
    alu1bit u_bit (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .op   (op),
      .s    (s[i]),
      .cout (c[i+1])
    );
  end

endmodule

// File: rtl/alu64bit_serial.sv
// Slice-serial ALU: processes SLICE bits per clock LSB-first, carry held in a flop,
// result presented on a valid/ready response port.
module alu64bit_serial
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned SLICE = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  alu64bit_serial_if.slave    bus,
  output logic                busy
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  if (WIDTH % SLICE != 0) begin : g_width_check
    $error("alu64bit_serial: WIDTH must be a multiple of SLICE");
  end

  alu_ser_state_e   state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q, b_q, work_q, work_d, s_q;
  alu_op_e          op_q;
  logic             cout_q;

  logic [SLICE-1:0] a_sl, b_sl, s_sl;
  logic             c_sl;
  logic             last_slice;

  // Operand slice select and working-reg merge share one index decode on cnt_q.
  always_comb begin
    a_sl   = '0;
    b_sl   = '0;
    work_d = work_q;
    for (int unsigned i = 0; i < NSLICE; i++) begin
      if (cnt_q == CNT_W'(i)) begin
        a_sl                     = a_q[i*SLICE +: SLICE];
        b_sl                     = b_q[i*SLICE +: SLICE];
        work_d[i*SLICE +: SLICE] = s_sl;
      end
    end
  end

  assign last_slice = (cnt_q == CNT_W'(NSLICE - 1));

  alu_slice #(.SLICE(SLICE)) u_slice (
    .a    (a_sl),
    .b    (b_sl),
    .cin  (carry_q),
    .op   (op_q),
    .s    (s_sl),
    .cout (c_sl)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    busy          = 1'b1;
    case (state_q)
      S_IDLE: begin
        bus.in_ready = 1'b1;
        busy         = 1'b0;
        if (bus.in_valid) state_d = S_CALC;
      end
      S_CALC: if (last_slice) state_d = S_DONE;
      S_DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_NOR;
      work_q  <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (bus.in_valid) begin
          a_q     <= bus.a;
          b_q     <= bus.b;
          op_q    <= bus.op;
          carry_q <= bus.cin;
          cnt_q   <= '0;
          work_q  <= '0;
        end
        S_CALC: begin
          work_q  <= work_d;
          carry_q <= c_sl;
          if (last_slice) begin
            cnt_q  <= '0;
            s_q    <= work_d;
            cout_q <= c_sl;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.s    = s_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_alu64bit_serial.sv
// Scoreboard bench for alu64bit_serial: driver pushes expected {cout,s}, monitor pops on handshake.
module tb_alu64bit_serial;
  import alu_pkg::*;

  localparam int unsigned WIDTH  = 64;
  localparam int unsigned SLICE  = 8;
  localparam int unsigned NSLICE = WIDTH / SLICE;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;

  alu64bit_serial_if #(.WIDTH(WIDTH)) bus ();

  alu64bit_serial #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [WIDTH:0] sb_q[$];
  int             lat_q[$];

  task automatic chk(input string name, input logic [WIDTH:0] act, input logic [WIDTH:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got timeout/unexpected event expected none", name);
  endtask

  // Reference: whole-word arithmetic, returns {cout, s}.
  function automatic logic [WIDTH:0] ref_model(input logic [1:0] op, input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b, input logic cin);
    logic [WIDTH:0] c;
    c = {{WIDTH{1'b0}}, cin};
    case (op)
      2'b00:   return {1'b0, ~(a | b)};
      2'b01:   return {1'b0, a ^ b};
      2'b10:   return {1'b0, a} + {1'b0, b} + c;
      default: return {1'b0, a} + {1'b0, ~b} + c;
    endcase
  endfunction

  // Monitor: latency on rising out_valid, result compare on handshake.
  logic prev_ov = 1'b0;
  int   acc_mon;
  always @(negedge clk) begin
    if (bus.out_valid && !prev_ov) begin
      if (lat_q.size() == 0) fail_now("unexpected_out_valid");
      else begin
        acc_mon = lat_q.pop_front();
        chk("latency", (WIDTH+1)'(cyc - acc_mon), (WIDTH+1)'(NSLICE));
      end
    end
    if (bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) fail_now("unexpected_response");
      else chk("result", {bus.cout, bus.s}, sb_q.pop_front());
    end
    prev_ov = bus.out_valid;
  end

  task automatic issue(input logic [1:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic cin, input logic [WIDTH:0] exp, input bit want,
                       input bit hold, output int acc);
    int n = 0;
    acc = -1;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      fail_now("issue_timeout");
      return;
    end
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.cin      = cin;
    bus.op       = alu_op_e'(op);
    @(posedge clk);
    #1;
    acc = cyc;
    if (want) begin
      sb_q.push_back(exp);
      lat_q.push_back(cyc);
    end
    if (!hold) bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb_q.size() != 0 || !bus.in_ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) fail_now("drain_timeout");
  endtask

  initial begin
    int acc, prev_acc, n;
    logic [1:0]       rop;
    logic [WIDTH-1:0] ra, rb;
    logic             rc;

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.op        = OP_NOR;
    bus.out_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_s", bus.s, 0);
    chk("rst_cout", bus.cout, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;

    issue(2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, {1'b1, 64'h0}, 1, 0, acc);
    wait_drain();
    issue(2'b11, 64'd5, 64'd7, 1'b1, {1'b0, 64'hFFFF_FFFF_FFFF_FFFE}, 1, 0, acc);
    wait_drain();
    issue(2'b11, 64'd7, 64'd5, 1'b1, {1'b1, 64'd2}, 1, 0, acc);
    wait_drain();
    issue(2'b00, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 1'b1,
          {1'b0, 64'h000F_000F_000F_000F}, 1, 0, acc);
    wait_drain();
    issue(2'b01, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 1'b1,
          {1'b0, 64'h0FF0_0FF0_0FF0_0FF0}, 1, 0, acc);
    wait_drain();

    // Backpressure with a competing request held during DONE.
    bus.out_ready = 1'b0;
    issue(2'b10, 64'd123, 64'd456, 1'b0, {1'b0, 64'd579}, 1, 0, acc);
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) fail_now("bp_wait_out_valid");
    bus.in_valid = 1'b1;
    bus.a        = 64'd3;
    bus.b        = 64'd5;
    bus.cin      = 1'b0;
    bus.op       = OP_XOR;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_s_cout", {bus.cout, bus.s}, {1'b0, 64'd579});
      chk("bp_out_valid", bus.out_valid, 1);
      chk("bp_in_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    issue(2'b01, 64'd3, 64'd5, 1'b0, {1'b0, 64'd6}, 1, 0, acc);
    wait_drain();

    // Reset while slice 3 is being computed.
    issue(2'b10, 64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, '0, 0, 0, acc);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_s", bus.s, 0);
    chk("midrst_cout", bus.cout, 0);
    chk("midrst_in_ready", bus.in_ready, 1);
    chk("midrst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(2'b10, 64'd1, 64'd1, 1'b0, {1'b0, 64'd2}, 1, 0, acc);
    wait_drain();

    // Back-to-back random ops, in_valid and out_ready held high.
    prev_acc = 0;
    for (int k = 0; k < 20; k++) begin
      rop = 2'($urandom_range(3));
      ra  = {$urandom, $urandom};
      rb  = (k % 5 == 0) ? ~ra : {$urandom, $urandom};
      rc  = 1'($urandom_range(1));
      issue(rop, ra, rb, rc, ref_model(rop, ra, rb, rc), 1, 1, acc);
      if (k > 0) chk("b2b_spacing", (WIDTH+1)'(acc - prev_acc), (WIDTH+1)'(NSLICE + 2));
      prev_acc = acc;
    end
    bus.in_valid = 1'b0;
    wait_drain();
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion expected finish");
    $fatal(1, "global timeout");
  end

endmodule
